// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline fetch stage: PCSrc encodings, NOP word,
// reset/trap vectors, IF/ID load-select type and the kernel-preserving PC+4 helper.
package pipeline_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
  localparam logic [2:0] PCSRC_XADR   = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  // What the IF/ID register does on a non-stalled edge.
  typedef enum logic [0:0] {
    IfSelLoad,
    IfSelBubble
  } if_sel_e;

  // PC+4 never changes the kernel bit; the low 31 bits wrap on their own.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC priority mux for the fetch stage (stall handled by the caller).
// Order: trap vectors, jump, jump-register, branch, imem wait, sequential.
module if_next_pc
  import pipeline_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = ILLOP_VEC,
  parameter logic [31:0] XADR_PC  = XADR_VEC
) (
  input  logic [31:0] pc_i,
  input  logic [3:0]  id_pc_hi_i,
  input  logic [2:0]  pcsrc_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] conba_i,
  input  logic [25:0] jt_i,
  input  logic [31:0] pcout_i,
  input  logic        imem_ready_i,
  output logic [31:0] next_pc_o,
  output if_sel_e     sel_o
);

  // Priority select of the next PC; everything except a sequential fetch bubbles IF/ID.
  always_comb begin
    next_pc_o = pc_i;
    sel_o     = IfSelBubble;
    if (pcsrc_i == PCSRC_ILLOP) begin
      next_pc_o = ILLOP_PC;
    end else if (pcsrc_i == PCSRC_XADR) begin
      next_pc_o = XADR_PC;
    end else if (jump_i && (pcsrc_i == PCSRC_JUMP)) begin
      next_pc_o = {id_pc_hi_i, jt_i, 2'b00};
    end else if (jump_i && (pcsrc_i == PCSRC_JR)) begin
      next_pc_o = pcout_i;
    end else if (branch_i) begin
      next_pc_o = conba_i;
    end else if (!imem_ready_i) begin
      // Pending fetch keeps its address until the memory answers.
      next_pc_o = pc_i;
    end else begin
      next_pc_o = pc_plus4(pc_i);
      sel_o     = IfSelLoad;
    end
  end

endmodule

// File: rtl/pipeline_if_stage.sv
// Fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise the counter ports are tied to zero.
module pipeline_if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VEC,
  parameter logic [31:0] ILLOP_PC = ILLOP_VEC,
  parameter logic [31:0] XADR_PC  = XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_stall,
  input  logic [2:0]  PCSrc,
  input  logic        IDcontrol_Branch,
  input  logic        IDcontrol_Jump,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] PCout,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instruction,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] next_pc;
  if_sel_e     sel;

  if_next_pc #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_next_pc (
    .pc_i         (pc_q),
    .id_pc_hi_i   (id_pc_q[31:28]),
    .pcsrc_i      (PCSrc),
    .branch_i     (IDcontrol_Branch),
    .jump_i       (IDcontrol_Jump),
    .conba_i      (ConBA),
    .jt_i         (JT),
    .pcout_i      (PCout),
    .imem_ready_i (imem_ready),
    .next_pc_o    (next_pc),
    .sel_o        (sel)
  );

  // Stall freezes everything; otherwise either load the fetched word or bubble.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (!IF_stall) begin
      pc_d = {next_pc[31:2], 2'b00};
      if (sel == IfSelLoad) begin
        id_pc_d    = pc_d;  // the sequential next PC is PC+4 of the loaded word
        id_instr_d = imem_rdata;
      end else begin
        id_instr_d = NOP_INSTR;
      end
    end
  end

  // PC and IF/ID state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign imem_addr      = pc_q;
  assign ID_PC          = id_pc_q;
  assign ID_instruction = id_instr_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count loads and bubbles on non-stalled edges; both wrap naturally.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!IF_stall) begin
      if (sel == IfSelLoad) fetch_cnt_d = fetch_cnt_q + 32'd1;
      else                  bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Scoreboard bench for pipeline_if_stage: directed steps push expected state,
// a monitor pops and compares after each clock edge or asynchronous event.
module tb_pipeline_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IF_stall = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic        IDcontrol_Branch = 1'b0;
  logic        IDcontrol_Jump = 1'b0;
  logic [31:0] ConBA = 32'h0;
  logic [25:0] JT = 26'h0;
  logic [31:0] PCout = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  pipeline_if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .IF_stall         (IF_stall),
    .PCSrc            (PCSrc),
    .IDcontrol_Branch (IDcontrol_Branch),
    .IDcontrol_Jump   (IDcontrol_Jump),
    .ConBA            (ConBA),
    .JT               (JT),
    .PCout            (PCout),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .ID_PC            (ID_PC),
    .ID_instruction   (ID_instruction),
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_bubble_cnt  (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] idpc;
    logic [31:0] idi;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_id = 0;
  event chk_ev;

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef IF_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic cmp(input int id, input string fld, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL step%0d %s: got %h expected %h", id, fld, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] idpc, input logic [31:0] idi,
                      input logic [31:0] fc, input logic [31:0] bc);
    exp_t e;
    e.id = step_id;
    e.pc = pc;
    e.idpc = idpc;
    e.idi = idi;
    e.fc = cnt(fc);
    e.bc = cnt(bc);
    exp_q.push_back(e);
    step_id++;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the post-edge state.
  task automatic step(input logic st, input logic jmp, input logic br, input logic [2:0] src,
                      input logic [31:0] cba, input logic [25:0] jt, input logic [31:0] pco,
                      input logic rdy, input logic [31:0] rd,
                      input logic [31:0] pc, input logic [31:0] idpc, input logic [31:0] idi,
                      input logic [31:0] fc, input logic [31:0] bc);
    @(negedge clk);
    IF_stall = st;
    IDcontrol_Jump = jmp;
    IDcontrol_Branch = br;
    PCSrc = src;
    ConBA = cba;
    JT = jt;
    PCout = pco;
    imem_ready = rdy;
    imem_rdata = rd;
    push(pc, idpc, idi, fc, bc);
  endtask

  // Monitor: compare after every edge or explicit asynchronous check point.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.id, "pc", imem_addr, e.pc);
        cmp(e.id, "id_pc", ID_PC, e.idpc);
        cmp(e.id, "id_instr", ID_instruction, e.idi);
        cmp(e.id, "fetch_cnt", perf_fetch_cnt, e.fc);
        cmp(e.id, "bubble_cnt", perf_bubble_cnt, e.bc);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(32'h8000_0000, 32'h0, 32'h0, 0, 0);
    ->chk_ev;

    //   st jmp br src   ConBA          JT            PCout         rdy rdata
    //   -> pc           id_pc          id_instr      fetch bubble
    step(0, 0, 1, 3'd1, 32'h0000_0040, 26'h0, 32'h0, 1, 32'h1111_1111,
         32'h0000_0040, 32'h0, 32'h0, 0, 1);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h2002_000A,
         32'h0000_0044, 32'h0000_0044, 32'h2002_000A, 1, 1);
    step(0, 0, 1, 3'd1, 32'h0000_0100, 26'h0, 32'h0, 1, 32'hDEAD_BEEF,
         32'h0000_0100, 32'h0000_0044, 32'h0, 1, 2);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h8C22_0004,
         32'h0000_0104, 32'h0000_0104, 32'h8C22_0004, 2, 2);
    // Stall over a pending jump for two cycles.
    step(1, 1, 0, 3'd2, 32'h0, 26'h0001234, 32'h0, 1, 32'h0000_0055,
         32'h0000_0104, 32'h0000_0104, 32'h8C22_0004, 2, 2);
    step(1, 1, 0, 3'd2, 32'h0, 26'h0001234, 32'h0, 1, 32'h0000_0055,
         32'h0000_0104, 32'h0000_0104, 32'h8C22_0004, 2, 2);
    step(0, 1, 0, 3'd2, 32'h0, 26'h0001234, 32'h0, 1, 32'h0000_0055,
         32'h0000_48D0, 32'h0000_0104, 32'h0, 2, 3);
    step(0, 1, 0, 3'd3, 32'h0, 26'h0, 32'h0000_0200, 1, 32'h0000_0066,
         32'h0000_0200, 32'h0000_0104, 32'h0, 2, 4);
    // Memory wait, then interrupt while still waiting.
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0077,
         32'h0000_0200, 32'h0000_0104, 32'h0, 2, 5);
    step(0, 0, 0, 3'd5, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0077,
         32'h8000_0008, 32'h0000_0104, 32'h0, 2, 6);
    step(0, 0, 0, 3'd4, 32'h0, 26'h0, 32'h0, 1, 32'h0000_0088,
         32'h8000_0004, 32'h0000_0104, 32'h0, 2, 7);
    // Jump flag with a non-jump PCSrc falls through to sequential.
    step(0, 1, 0, 3'd0, 32'h0, 26'h3FF_FFFF, 32'h0000_0300, 1, 32'h0123_4567,
         32'h8000_0008, 32'h8000_0008, 32'h0123_4567, 3, 7);
    // PC+4 wrap in both halves of the address space.
    step(0, 0, 1, 3'd1, 32'h7FFF_FFFC, 26'h0, 32'h0, 1, 32'h0000_0099,
         32'h7FFF_FFFC, 32'h8000_0008, 32'h0, 3, 8);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h0000_000A,
         32'h0000_0000, 32'h0000_0000, 32'h0000_000A, 4, 8);
    step(0, 0, 1, 3'd1, 32'hFFFF_FFFC, 26'h0, 32'h0, 1, 32'h0000_0099,
         32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 4, 9);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h0000_000B,
         32'h8000_0000, 32'h8000_0000, 32'h0000_000B, 5, 9);

    // Reset asserted between edges takes effect immediately.
    @(negedge clk);
    IF_stall = 0; IDcontrol_Jump = 0; IDcontrol_Branch = 0; PCSrc = 3'd0;
    imem_ready = 1; imem_rdata = 32'h0000_000C;
    #2;
    push(32'h8000_0000, 32'h0, 32'h0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;

    // Three loads and two bubbles from reset.
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h0000_0001,
         32'h8000_0004, 32'h8000_0004, 32'h0000_0001, 1, 0);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_00EE,
         32'h8000_0004, 32'h8000_0004, 32'h0, 1, 1);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h0000_0002,
         32'h8000_0008, 32'h8000_0008, 32'h0000_0002, 2, 1);
    step(0, 0, 1, 3'd1, 32'h0000_0300, 26'h0, 32'h0, 1, 32'h0000_00EE,
         32'h0000_0300, 32'h8000_0008, 32'h0, 2, 2);
    step(0, 0, 0, 3'd0, 32'h0, 26'h0, 32'h0, 1, 32'h0000_0003,
         32'h0000_0304, 32'h0000_0304, 32'h0000_0003, 3, 2);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
